// File: rtl/sonar_ranger.sv
// Ultrasonic ranger controller. It sends a trigger pulse, times the echo
// pulse and converts the echo width to millimetres (about 6 us per mm,
// round trip). It can range periodically or on a single-shot request. A
// missing echo or a stuck echo ends the attempt with a timeout pulse.
module sonar_ranger #(
  parameter int INPUT_CLK_FREQ = 12_000_000,
  parameter int MEAS_PERIOD_MS = 100,
  parameter int TRIG_US        = 10,
  parameter int TIMEOUT_US     = 30000,
  parameter int MAX_MM         = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  input  logic        sonar_echo,
  output logic        sonar_trig,
  output logic [15:0] dist_mm,
  output logic        dist_valid,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CLKS_PER_US = INPUT_CLK_FREQ / 1_000_000;
  localparam int TRIG_CYC    = TRIG_US * CLKS_PER_US;
  localparam int TIMEOUT_CYC = TIMEOUT_US * CLKS_PER_US;
  localparam int PERIOD_CYC  = MEAS_PERIOD_MS * 1000 * CLKS_PER_US;
  localparam int TMR_MAX     = (TRIG_CYC > TIMEOUT_CYC) ? TRIG_CYC : TIMEOUT_CYC;
  localparam int TMR_W       = $clog2(TMR_MAX + 1);
  localparam int PER_W       = $clog2(PERIOD_CYC + 1);
  localparam int PRE_W       = $clog2(CLKS_PER_US + 1);

  localparam logic [TMR_W-1:0] TRIG_LAST    = TMR_W'(TRIG_CYC);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [PER_W-1:0] PER_RELOAD   = PER_W'(PERIOD_CYC);
  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(CLKS_PER_US - 1);
  localparam logic [15:0]      MM_MAX       = 16'(MAX_MM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t             state, next_state;
  logic               echo_s1, echo_sync, echo_d;
  logic               echo_rise;
  logic               period_expired;
  logic [TMR_W-1:0]   timer;
  logic [PER_W-1:0]   period_cnt;
  logic [PRE_W-1:0]   us_pre;
  logic [2:0]         sub6;
  logic [15:0]        mm_cnt;

  // Two-flop echo synchronizer, plus one more flop for edge detection
  // and for echo-width counting.
  // NOTE: sequential blocks use non-blocking (<=) assignments so every flop
  // samples the values from before the clock edge; blocking (=) here would
  // collapse the synchronizer chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1   <= 1'b0;
      echo_sync <= 1'b0;
      echo_d    <= 1'b0;
    end else begin
      echo_s1   <= sonar_echo;
      echo_sync <= echo_s1;
      echo_d    <= echo_sync;
    end
  end

  assign echo_rise = echo_sync & ~echo_d;
  assign busy      = (state != S_IDLE);

  // Expiry is flagged one count before zero. The start that follows then
  // lands exactly PERIOD_CYC cycles after the previous one.
  assign period_expired = (period_cnt <= PER_W'(1));

  // Next-state logic for the ranging sequence.
  // NOTE: next_state gets a default before the case. Every path then
  // assigns it, so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:
        if (!echo_sync && (start || (enable && period_expired)))
          next_state = S_TRIG;
      S_TRIG:
        if (timer == TRIG_LAST) next_state = S_WAIT_ECHO;
      S_WAIT_ECHO:
        if (echo_rise)                  next_state = S_MEASURE;
        else if (timer == TIMEOUT_LAST) next_state = S_IDLE;
      S_MEASURE:
        if (!echo_sync)                 next_state = S_DONE;
        else if (timer == TIMEOUT_LAST) next_state = S_IDLE;
      S_DONE:
        next_state = S_IDLE;
      default:
        next_state = S_IDLE;
    endcase
  end

  // State register, and a per-state cycle timer that clears on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= next_state;
      if (next_state != state || state == S_IDLE) timer <= '0;
      else                                        timer <= timer + 1'b1;
    end
  end

  // Period counter: reloads when a measurement starts, then counts down
  // to zero and holds there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      period_cnt <= '0;
    else if (state == S_IDLE && next_state == S_TRIG)
      period_cnt <= PER_RELOAD;
    else if (period_cnt != '0)
      period_cnt <= period_cnt - 1'b1;
  end

  // Echo-width to mm conversion. echo_d is aligned with the MEASURE
  // cycles, so the rising-edge cycle is counted and the falling edge ends
  // the count. The count saturates at MAX_MM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_pre <= '0;
      sub6   <= '0;
      mm_cnt <= '0;
    end else if (state != S_MEASURE && next_state == S_MEASURE) begin
      us_pre <= '0;
      sub6   <= '0;
      mm_cnt <= '0;
    end else if (state == S_MEASURE && echo_d) begin
      if (us_pre == PRE_LAST) begin
        us_pre <= '0;
        if (sub6 == 3'd5) begin
          sub6 <= '0;
          if (mm_cnt < MM_MAX) mm_cnt <= mm_cnt + 16'd1;
        end else begin
          sub6 <= sub6 + 3'd1;
        end
      end else begin
        us_pre <= us_pre + 1'b1;
      end
    end
  end

  // Registered outputs: the trigger pulse, result loading and the status
  // pulses. Results load only from DONE and timeouts only from the wait
  // and measure states, so the two pulses are never high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sonar_trig  <= 1'b0;
      dist_mm     <= '0;
      dist_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sonar_trig  <= (state == S_TRIG) && (next_state == S_TRIG);
      dist_valid  <= (state == S_DONE);
      timeout_err <= (state == S_WAIT_ECHO || state == S_MEASURE) &&
                     (next_state == S_IDLE);
      if (state == S_DONE) dist_mm <= mm_cnt;
    end
  end

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger. It uses scaled parameters so that whole
// ranging periods fit in a short run: 2 MHz clock (2 clocks/us), 1 ms
// period, 10 us trigger and 800 us timeout. One mm is 12 echo-high clocks.
module tb_sonar_ranger;

  localparam int TRIG_CYC    = 20;    // 10 us * 2
  localparam int TIMEOUT_CYC = 1600;  // 800 us * 2
  localparam int PERIOD_CYC  = 2000;  // 1 ms * 1000 * 2
  localparam int MM_CLKS     = 12;    // 6 us * 2
  localparam int SAT_MM      = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        sonar_echo = 1'b0;
  logic        sonar_trig;
  logic [15:0] dist_mm;
  logic        dist_valid;
  logic        timeout_err;
  logic        busy;

  sonar_ranger #(
    .INPUT_CLK_FREQ(2_000_000),
    .MEAS_PERIOD_MS(1),
    .TRIG_US       (10),
    .TIMEOUT_US    (800),
    .MAX_MM        (SAT_MM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .sonar_echo (sonar_echo),
    .sonar_trig (sonar_trig),
    .dist_mm    (dist_mm),
    .dist_valid (dist_valid),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event monitors, sampled on the falling edge.
  int   cyc = 0;
  int   valid_cnt = 0;
  int   terr_cnt = 0;
  int   both_cnt = 0;
  int   trig_rises = 0;
  logic trig_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (dist_valid === 1'b1) valid_cnt++;
    if (timeout_err === 1'b1) terr_cnt++;
    if (dist_valid === 1'b1 && timeout_err === 1'b1) both_cnt++;
    if (sonar_trig === 1'b1 && trig_q !== 1'b1) trig_rises++;
    trig_q = sonar_trig;
  end

  // Every bench action happens just after a falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_trig(input int budget, output int waited);
    waited = 0;
    while (sonar_trig !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  // One measurement. side: 0 none, 1 START pulse during echo, 2 drop ENABLE
  // before the echo.
  task automatic run_meas(input string tag, input int budget, input int delay,
                          input int width, input int exp_mm, input int side,
                          output int t_rise);
    int w, hi, n, v0;
    wait_trig(budget, w);
    check({tag, "_trig_seen"}, sonar_trig, 1);
    t_rise = cyc;
    hi = 0;
    while (sonar_trig === 1'b1 && hi < 200) begin
      tick();
      hi++;
    end
    check({tag, "_trig_width"}, hi, TRIG_CYC);
    if (side == 2) enable = 1'b0;
    v0 = valid_cnt;
    repeat (delay) tick();
    sonar_echo = 1'b1;
    for (int i = 0; i < width; i++) begin
      start = (side == 1) && (i == width / 2);
      tick();
    end
    start = 1'b0;
    sonar_echo = 1'b0;
    n = 0;
    while (dist_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, dist_valid, 1);
    check({tag, "_dist"}, dist_mm, exp_mm);
    tick();
    check({tag, "_valid_pulses"}, valid_cnt - v0, 1);
  endtask

  initial begin
    int t_prev, t_now, w, n, r0, e0, v0;

    // Reset state
    repeat (3) tick();
    check("rst_trig", sonar_trig, 0);
    check("rst_dist", dist_mm, 0);
    check("rst_valid", dist_valid, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_trig", trig_rises, 0);

    // Single shot with ENABLE low. A START pulse while busy must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_meas("shot", 10, 50, 120, 10, 1, t_now);
    r0 = trig_rises;
    repeat (300) tick();
    check("shot_no_retrig", trig_rises - r0, 0);

    // Periodic sequence: widths include remainders to check floor().
    enable = 1'b1;
    run_meas("seq0", 2100, 100, 912, 76, 0, t_prev);
    run_meas("seq1", 2100, 60, 1037, 86, 0, t_now);
    check("seq1_spacing", t_now - t_prev, PERIOD_CYC);
    t_prev = t_now;
    run_meas("seq2", 2100, 200, 731, 60, 0, t_now);
    check("seq2_spacing", t_now - t_prev, PERIOD_CYC);
    t_prev = t_now;
    run_meas("seq3", 2100, 100, 1143, 95, 0, t_now);
    check("seq3_spacing", t_now - t_prev, PERIOD_CYC);
    t_prev = t_now;
    run_meas("seq4", 2100, 300, 535, 44, 0, t_now);
    check("seq4_spacing", t_now - t_prev, PERIOD_CYC);
    t_prev = t_now;

    // No echo: timeout measured from WAIT_ECHO entry (trigger fall).
    wait_trig(2100, w);
    check("noecho_trig_seen", sonar_trig, 1);
    check("noecho_spacing", cyc - t_prev, PERIOD_CYC);
    t_prev = cyc;
    while (sonar_trig === 1'b1 && w < 5000) begin
      tick();
      w++;
    end
    v0 = valid_cnt;
    e0 = terr_cnt;
    n = 0;
    while (timeout_err !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("noecho_terr_delay", n, TIMEOUT_CYC);
    check("noecho_dist_held", dist_mm, 44);
    tick();
    check("noecho_terr_pulses", terr_cnt - e0, 1);
    check("noecho_no_valid", valid_cnt - v0, 0);

    // Stuck echo: timeout in MEASURE, then no trigger until echo drops.
    wait_trig(2100, w);
    check("stuck_spacing", cyc - t_prev, PERIOD_CYC);
    while (sonar_trig === 1'b1 && w < 5000) begin
      tick();
      w++;
    end
    repeat (50) tick();
    sonar_echo = 1'b1;
    n = 0;
    while (timeout_err !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("stuck_terr", timeout_err, 1);
    check("stuck_dist_held", dist_mm, 44);
    r0 = trig_rises;
    repeat (2500) tick();
    check("stuck_no_trig", trig_rises - r0, 0);
    sonar_echo = 1'b0;
    wait_trig(10, w);
    check("stuck_release_lat", w, 4);
    run_meas("sat", 0, 80, 1500, SAT_MM, 0, t_prev);

    // ENABLE dropped mid-measurement: completes, then ranging stops.
    run_meas("endrop", 2100, 30, 243, 20, 2, t_now);
    check("endrop_spacing", t_now - t_prev, PERIOD_CYC);
    r0 = trig_rises;
    repeat (2500) tick();
    check("endrop_stopped", trig_rises - r0, 0);

    // Reset during TRIG drops the trigger and clears the result at once.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_trig(10, w);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("rst_trig_drop", sonar_trig, 0);
    check("rst_trig_dist", dist_mm, 0);
    check("rst_trig_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_meas("shot2", 10, 40, 187, 15, 0, t_now);

    // Reset during MEASURE, then recovery with ENABLE and START together.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_trig(10, w);
    n = 0;
    while (sonar_trig === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    repeat (20) tick();
    sonar_echo = 1'b1;
    repeat (100) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_meas_dist", dist_mm, 0);
    check("rst_meas_busy", busy, 0);
    check("rst_meas_trig", sonar_trig, 0);
    check("rst_meas_valid", dist_valid, 0);
    check("rst_meas_terr", timeout_err, 0);
    sonar_echo = 1'b0;
    repeat (3) tick();
    r0 = trig_rises;
    rst_n = 1'b1;
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_trig(10, w);
    check("recover_trig_lat", w, 1);
    run_meas("recover", 0, 25, 397, 33, 0, t_now);
    check("recover_one_meas", trig_rises - r0, 1);
    enable = 1'b0;

    check("valid_terr_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
